// File: rtl/cbm2_cycle_sequencer.sv
// Bus-cycle sequencer for the CBM-II core.
// A free-running slot counter defines a repeating frame. Each requester channel
// owns the bus during a programmable slot window, gated by a frame-phase
// qualifier and an optional refresh-frame mask. The block also paces SDRAM
// refresh (one pulse every 2^RFSH_BITS frames), acknowledges pause requests at
// refresh boundaries and divides the clock down to a pixel enable.
module cbm2_cycle_sequencer #(
  parameter int NUM_CH    = 4,
  parameter int SLOT_W    = 5,
  parameter int RFSH_BITS = 3
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic [SLOT_W-1:0]        frame_end,
  input  logic [NUM_CH*SLOT_W-1:0] ch_start,
  input  logic [NUM_CH*SLOT_W-1:0] ch_end,
  input  logic [NUM_CH*2-1:0]      ch_phq,
  input  logic [NUM_CH-1:0]        ch_rfsh_mask,
  input  logic                     pause,
  output logic [SLOT_W-1:0]        slot,
  output logic                     phase,
  output logic [NUM_CH-1:0]        ch_cycle,
  output logic [NUM_CH-1:0]        ch_strobe,
  output logic                     refresh,
  output logic                     rfsh_frame,
  output logic                     running,
  output logic                     pause_out,
  output logic                     pix_ce
);

  logic [SLOT_W-1:0]    cnt_reg;
  logic                 phase_reg;
  logic [RFSH_BITS-1:0] rfcnt_reg;
  logic                 running_reg;
  logic                 refresh_reg;
  logic [1:0]           pcnt_reg;

  // Greater-or-equal so that shrinking frame_end below the current slot ends
  // the frame on the very next clock instead of wrapping the whole counter.
  logic frame_last;
  assign frame_last = (cnt_reg >= frame_end);

  // Slot counter, frame phase, refresh cadence, pause acknowledge and pixel divider.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg     <= '0;
      phase_reg   <= 1'b0;
      rfcnt_reg   <= '0;
      running_reg <= 1'b0;
      refresh_reg <= 1'b0;
      pcnt_reg    <= 2'd0;
    end else begin
      // Divider restarts at every frame start so pix_ce stays frame-aligned.
      pcnt_reg    <= (!running_reg || frame_last) ? 2'd0 : pcnt_reg + 2'd1;
      refresh_reg <= 1'b0;
      if (frame_last) begin
        cnt_reg   <= '0;
        phase_reg <= ~phase_reg;
        rfcnt_reg <= rfcnt_reg + RFSH_BITS'(1);
        // Pause is only honoured on a refresh boundary so SDRAM refresh
        // cadence is never disturbed by entering or leaving pause.
        if (rfcnt_reg == '0) begin
          refresh_reg <= 1'b1;
          running_reg <= ~pause;
        end
      end else begin
        cnt_reg <= cnt_reg + SLOT_W'(1);
      end
    end
  end

  assign slot       = running_reg ? cnt_reg : '0;
  assign phase      = phase_reg;
  assign refresh    = refresh_reg;
  assign rfsh_frame = (rfcnt_reg == RFSH_BITS'(1));
  assign running    = running_reg;
  assign pause_out  = ~running_reg;
  assign pix_ce     = (pcnt_reg == 2'd3);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [SLOT_W-1:0] win_start;
      logic [SLOT_W-1:0] win_end;
      logic [1:0]        phq;
      logic              in_window;
      logic              phase_ok;
      logic              masked;

      assign win_start = ch_start[gi*SLOT_W +: SLOT_W];
      assign win_end   = ch_end[gi*SLOT_W +: SLOT_W];
      assign phq       = ch_phq[gi*2 +: 2];
      // A start above the end yields an empty window naturally.
      assign in_window = (slot >= win_start) && (slot <= win_end);
      assign masked    = ch_rfsh_mask[gi] && rfsh_frame;

      // Decode the phase qualifier: both, phase 1 only, phase 0 only, never.
      always_comb begin
        phase_ok = 1'b0;
        case (phq)
          2'd0:    phase_ok = 1'b1;
          2'd1:    phase_ok = phase_reg;
          2'd2:    phase_ok = ~phase_reg;
          default: phase_ok = 1'b0;
        endcase
      end

      // Windows are not arbitrated; overlapping grants are the programmer's choice.
      assign ch_cycle[gi]  = running_reg && in_window && phase_ok && !masked;
      assign ch_strobe[gi] = ch_cycle[gi] && (slot == win_end);
    end
  endgenerate

endmodule

// File: tb/tb_cbm2_cycle_sequencer.sv
// Directed bench for cbm2_cycle_sequencer: a vector table over the
// Professional frame plus hand sequences for pause, reset, frame-length,
// pixel-enable, empty-window and zero-length-frame corners.
module tb_cbm2_cycle_sequencer;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  frame_end;
  logic [19:0] ch_start;
  logic [19:0] ch_end;
  logic [7:0]  ch_phq;
  logic [3:0]  ch_rfsh_mask;
  logic        pause;
  logic [4:0]  slot;
  logic        phase;
  logic [3:0]  ch_cycle;
  logic [3:0]  ch_strobe;
  logic        refresh;
  logic        rfsh_frame;
  logic        running;
  logic        pause_out;
  logic        pix_ce;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  cbm2_cycle_sequencer #(.NUM_CH(4), .SLOT_W(5), .RFSH_BITS(3)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .frame_end(frame_end),
    .ch_start(ch_start), .ch_end(ch_end), .ch_phq(ch_phq),
    .ch_rfsh_mask(ch_rfsh_mask), .pause(pause), .slot(slot), .phase(phase),
    .ch_cycle(ch_cycle), .ch_strobe(ch_strobe), .refresh(refresh),
    .rfsh_frame(rfsh_frame), .running(running), .pause_out(pause_out),
    .pix_ce(pix_ce)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int         cyc;
    logic [4:0] slot;
    logic [3:0] cyc_e;
    logic [3:0] stb_e;
    logic       ph;
    logic       rf;
    logic       rff;
    logic       pix;
    logic       po;
  } vec_t;

  vec_t vecs [23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end else begin
      $display("[TB] %s @cyc %0d ok: %0h", name, cyc, act);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
    cyc++;
  endtask

  task automatic tick_to(input int n);
    while (cyc < n) tick();
  endtask

  // EXT 0..3 phase1+mask, CPU 4..7, ch2/ch3 overlapping on 12..13.
  task automatic cfg_default(input logic [4:0] fe);
    frame_end    = fe;
    ch_start     = {5'd12, 5'd12, 5'd4, 5'd0};
    ch_end       = {5'd13, 5'd13, 5'd7, 5'd3};
    ch_phq       = {2'd0, 2'd0, 2'd0, 2'd1};
    ch_rfsh_mask = 4'b0001;
    pause        = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk_sys);
    #1;
    @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    cyc = 0;
  endtask

  function automatic logic [17:0] all_out();
    return {slot, ch_cycle, ch_strobe, phase, refresh, rfsh_frame, pix_ce, pause_out};
  endfunction

  initial begin
    // cyc, slot, ch_cycle, ch_strobe, phase, refresh, rfsh_frame, pix_ce, pause_out
    vecs[0]  = '{0,   5'd0,  4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{5,   5'd0,  4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{15,  5'd0,  4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{16,  5'd0,  4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{17,  5'd1,  4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{19,  5'd3,  4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{20,  5'd4,  4'h2, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{23,  5'd7,  4'h2, 4'h2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{24,  5'd8,  4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{28,  5'd12, 4'hC, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{29,  5'd13, 4'hC, 4'hC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{31,  5'd15, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{32,  5'd0,  4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{35,  5'd3,  4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{36,  5'd4,  4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{48,  5'd0,  4'h1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{51,  5'd3,  4'h1, 4'h1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{52,  5'd4,  4'h2, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{128, 5'd0,  4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{144, 5'd0,  4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[20] = '{147, 5'd3,  4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[21] = '{160, 5'd0,  4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[22] = '{176, 5'd0,  4'h1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state, before any clock edge.
    cfg_default(5'd15);
    #1;
    chk("reset_outputs", 32'(all_out()), 32'h1);
    chk("reset_running", 32'(running), 32'h0);

    // Vector table over the Professional frame.
    do_reset();
    for (int i = 0; i < 23; i++) begin
      tick_to(vecs[i].cyc);
      chk($sformatf("vec%0d", i), 32'(all_out()),
          32'({vecs[i].slot, vecs[i].cyc_e, vecs[i].stb_e, vecs[i].ph,
               vecs[i].rf, vecs[i].rff, vecs[i].pix, vecs[i].po}));
    end

    // Asynchronous reset in the middle of the overlapped window.
    tick_to(188);
    chk("pre_reset_cycle", 32'(ch_cycle), 32'hC);
    reset_n = 1'b0;
    #1;
    chk("mid_reset_outputs", 32'(all_out()), 32'h1);

    // Empty window on ch3, then immediate re-programming takes effect.
    cfg_default(5'd15);
    ch_start[15 +: 5] = 5'd9;
    ch_end[15 +: 5]   = 5'd5;
    do_reset();
    tick_to(32);
    begin
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 16; k++) begin
        if (ch_cycle[3]) seen = 1'b1;
        if (cyc == 44) chk("other_ch_alive", 32'(ch_cycle[2]), 32'h1);
        tick();
      end
      chk("empty_window", 32'(seen), 32'h0);
    end
    tick_to(60);
    ch_start[15 +: 5] = 5'd12;
    ch_end[15 +: 5]   = 5'd13;
    #1;
    chk("window_live_update", 32'(ch_cycle), 32'hC);

    // Pause handshake.
    cfg_default(5'd15);
    do_reset();
    tick_to(40);
    pause = 1'b1;
    tick_to(143);
    chk("pause_not_yet", 32'(pause_out), 32'h0);
    tick();
    chk("pause_ack", 32'({pause_out, refresh, slot, ch_cycle}), 32'({1'b1, 1'b1, 5'd0, 4'h0}));
    tick_to(148);
    chk("paused_idle", 32'({slot, ch_cycle}), 32'h0);
    tick_to(150);
    pause = 1'b0;
    tick_to(271);
    chk("still_paused", 32'(pause_out), 32'h1);
    tick();
    chk("resume", 32'({pause_out, slot}), 32'h0);
    tick_to(276);
    chk("resume_cpu", 32'({slot, ch_cycle}), 32'({5'd4, 4'h2}));

    // Pixel enable on an 18-slot Business frame.
    cfg_default(5'd17);
    do_reset();
    tick_to(18);
    for (int k = 0; k < 21; k++) begin
      int c;
      logic e;
      c = (cyc - 18) % 18;
      e = (c == 3) || (c == 7) || (c == 11) || (c == 15);
      chk($sformatf("pix_ce_cnt%0d", c), 32'(pix_ce), 32'(e));
      tick();
    end

    // Shrinking the frame while the counter is already past the new end.
    cfg_default(5'd17);
    do_reset();
    tick_to(28);
    chk("switch_pre", 32'({slot, phase}), 32'({5'd10, 1'b1}));
    frame_end = 5'd3;
    tick();
    chk("switch_wrap", 32'({slot, phase}), 32'({5'd0, 1'b0}));
    tick_to(32);
    chk("switch_slot3", 32'({slot, pix_ce}), 32'({5'd3, 1'b1}));
    tick();
    chk("switch_frame2", 32'({slot, phase}), 32'({5'd0, 1'b1}));
    tick_to(37);
    chk("switch_frame3", 32'({slot, phase}), 32'({5'd0, 1'b0}));

    // Zero-length frame: every clock is a boundary.
    cfg_default(5'd0);
    do_reset();
    chk("fe0_c0", 32'({phase, pause_out}), 32'h1);
    tick();
    chk("fe0_c1", 32'({phase, pause_out, refresh, slot}), 32'({1'b1, 1'b0, 1'b1, 5'd0}));
    tick();
    chk("fe0_c2", 32'({phase, refresh}), 32'h0);
    tick();
    chk("fe0_c3", 32'(phase), 32'h1);
    tick_to(9);
    chk("fe0_refresh9", 32'(refresh), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
